// File: rtl/vx_tcu_uop_sequencer_pkg.sv
// Shared TCU micro-op sequencing definitions: default sizes, sequencer
// state encoding and the micro-op header that the TCU core decodes to
// locate its K-step position.
package vx_tcu_uop_sequencer_pkg;

  localparam int TCU_DATAW    = 64;
  localparam int TCU_MAX_UOPS = 8;
  localparam int TCU_CNTW     = $clog2(TCU_MAX_UOPS + 1);
  localparam int TCU_IDXW     = $clog2(TCU_MAX_UOPS);

  typedef enum logic [0:0] {
    SEQ_IDLE  = 1'b0,
    SEQ_ISSUE = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic [TCU_DATAW-1:0] data;
    logic [TCU_IDXW-1:0]  idx;
    logic                 first;
    logic                 last;
  } tcu_uop_hdr_t;

endpackage

// File: rtl/vx_tcu_uop_sequencer.sv
// TCU micro-op sequencer: holds one decoded WMMA instruction and emits one
// micro-op per K-step. The next instruction may be accepted in the same
// cycle the final micro-op is taken, so consecutive instructions stream
// without bubbles.
module vx_tcu_uop_sequencer
  import vx_tcu_uop_sequencer_pkg::*;
#(
  parameter int DATAW    = TCU_DATAW,
  parameter int MAX_UOPS = TCU_MAX_UOPS,
  parameter int CNTW     = $clog2(MAX_UOPS + 1),
  parameter int IDXW     = $clog2(MAX_UOPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  input  logic [CNTW-1:0]  in_count,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  output logic [IDXW-1:0]  out_uop_idx,
  output logic             out_first,
  output logic             out_last,
  input  logic             out_ready
);

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAX_UOPS);
  localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);

  // A zero count still issues one micro-op; oversize counts saturate.
  function automatic logic [CNTW-1:0] clamp_count(input logic [CNTW-1:0] c);
    logic [CNTW-1:0] r;
    if (c == '0) begin
      r = CNT_ONE;
    end else if (c > CNT_MAX) begin
      r = CNT_MAX;
    end else begin
      r = c;
    end
    return r;
  endfunction

  seq_state_e       state_r;
  seq_state_e       state_nxt_s;
  logic [DATAW-1:0] data_r;
  logic [IDXW-1:0]  idx_r;
  logic [CNTW-1:0]  cnt_r;
  logic             first_r;
  logic             last_r;

  logic             out_fire_s;
  logic             last_fire_s;
  logic             in_fire_s;
  logic             advance_s;
  logic [CNTW-1:0]  eff_cnt_s;
  logic [CNTW-1:0]  cnt_m1_s;
  logic             nxt_is_last_s;

  // Handshake decode; in_ready depends on out_ready but never on in_valid.
  assign out_fire_s    = out_valid & out_ready;
  assign last_fire_s   = out_fire_s & last_r;
  assign in_ready      = (state_r == SEQ_IDLE) | last_fire_s;
  assign in_fire_s     = in_valid & in_ready;
  assign advance_s     = out_fire_s & ~last_r;
  assign eff_cnt_s     = clamp_count(in_count);
  assign cnt_m1_s      = cnt_r - CNT_ONE;
  assign nxt_is_last_s = ((CNTW'(idx_r) + CNT_ONE) == cnt_m1_s);

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= SEQ_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: stay in ISSUE across back-to-back instructions.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      SEQ_IDLE: begin
        if (in_fire_s) begin
          state_nxt_s = SEQ_ISSUE;
        end else begin
          state_nxt_s = SEQ_IDLE;
        end
      end
      SEQ_ISSUE: begin
        if (last_fire_s && !in_fire_s) begin
          state_nxt_s = SEQ_IDLE;
        end else begin
          state_nxt_s = SEQ_ISSUE;
        end
      end
      default: state_nxt_s = SEQ_IDLE;
    endcase
  end

  // Output decode from registered state; flags are forced low when idle.
  always_comb begin
    out_valid = 1'b0;
    out_first = 1'b0;
    out_last  = 1'b0;
    case (state_r)
      SEQ_IDLE: begin
        out_valid = 1'b0;
        out_first = 1'b0;
        out_last  = 1'b0;
      end
      SEQ_ISSUE: begin
        out_valid = 1'b1;
        out_first = first_r;
        out_last  = last_r;
      end
      default: begin
        out_valid = 1'b0;
        out_first = 1'b0;
        out_last  = 1'b0;
      end
    endcase
  end

  // Payload, index and count registers: load on accept, step on each
  // non-final micro-op taken, otherwise hold so stalled outputs are stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r  <= '0;
      idx_r   <= '0;
      cnt_r   <= '0;
      first_r <= 1'b0;
      last_r  <= 1'b0;
    end else if (in_fire_s) begin
      data_r  <= in_data;
      idx_r   <= '0;
      cnt_r   <= eff_cnt_s;
      first_r <= 1'b1;
      last_r  <= (eff_cnt_s == CNT_ONE);
    end else if (advance_s) begin
      idx_r   <= idx_r + IDX_ONE;
      first_r <= 1'b0;
      last_r  <= nxt_is_last_s;
    end else begin
      data_r  <= data_r;
      idx_r   <= idx_r;
      cnt_r   <= cnt_r;
      first_r <= first_r;
      last_r  <= last_r;
    end
  end

  assign out_data    = data_r;
  assign out_uop_idx = idx_r;

endmodule

// File: tb/tb_vx_tcu_uop_sequencer.sv
// Scoreboard bench for vx_tcu_uop_sequencer: the driver pushes the expected
// micro-op stream when an instruction is accepted, and an independent monitor
// pops and compares each micro-op the DUT hands off.
module tb_vx_tcu_uop_sequencer;
  import vx_tcu_uop_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_data;
  logic [3:0]  in_count;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic [2:0]  out_uop_idx;
  logic        out_first;
  logic        out_last;
  logic        out_ready;

  vx_tcu_uop_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_count   (in_count),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_uop_idx(out_uop_idx),
    .out_first  (out_first),
    .out_last   (out_last),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  tcu_uop_hdr_t exp_q[$];
  bit           ready_pat[$];
  bit           rand_ready = 1'b0;
  int           nvec = 0;
  int           nerr = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int eff_count(input int c);
    if (c == 0) return 1;
    if (c > 8) return 8;
    return c;
  endfunction

  task automatic set_ready();
    if (ready_pat.size() > 0) out_ready = ready_pat.pop_front();
    else if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    else out_ready = 1'b1;
  endtask

  // Present one instruction and hold it until accepted; push its micro-ops.
  task automatic send(input logic [63:0] d, input int c, output int waits);
    int n;
    waits = 0;
    @(negedge clk);
    set_ready();
    in_valid = 1'b1;
    in_data  = d;
    in_count = c[3:0];
    #1;
    while (in_ready !== 1'b1 && waits < 500) begin
      waits++;
      @(negedge clk);
      set_ready();
      #1;
    end
    if (in_ready !== 1'b1) begin
      nvec++;
      nerr++;
      $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
    end else begin
      n = eff_count(c);
      for (int i = 0; i < n; i++) begin
        exp_q.push_back('{data: d, idx: i[2:0], first: (i == 0), last: (i == n - 1)});
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      set_ready();
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
      in_count = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
      idle(1);
      n++;
    end
    if (n >= 2000) begin
      nvec++;
      nerr++;
      $display("FAIL drain_timeout: %0d micro-ops still pending, required 0", exp_q.size());
    end
  endtask

  // Monitor: compare every accepted micro-op and require stalled outputs to hold.
  initial begin
    tcu_uop_hdr_t cur;
    tcu_uop_hdr_t prev_hdr;
    tcu_uop_hdr_t e;
    bit           stall_prev;
    stall_prev = 1'b0;
    prev_hdr   = '0;
    forever begin
      @(negedge clk);
      #2;
      cur = '{data: out_data, idx: out_uop_idx, first: out_first, last: out_last};
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) check("stall_hold", 128'({out_valid, cur}), 128'({1'b1, prev_hdr}));
        if (!out_valid) check("idle_flags", 128'({out_first, out_last}), 128'(2'b00));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_uop: got idx %0d data %h, required none", out_uop_idx, out_data);
          end else begin
            e = exp_q.pop_front();
            check("uop", 128'(cur), 128'(e));
          end
        end
        stall_prev = out_valid && !out_ready;
        prev_hdr   = cur;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 64'd0;
    in_count  = 4'd0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_state", 128'({out_valid, in_ready, out_first, out_last, out_uop_idx, out_data}),
          128'({1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 64'd0}));

    // Single instruction, count 4, full throughput: four consecutive micro-ops.
    send(64'hA1A1_0000_0000_0004, 4, w);
    idle(4);
    #3;
    check("t1_four_cycles", 128'(exp_q.size()), 128'(0));
    idle(1);
    #1;
    check("t1_then_idle", 128'(out_valid), 128'(1'b0));
    drain();

    // Back-to-back: second instruction accepted as the first's last micro-op fires.
    send(64'hB2B2_0000_0000_0002, 2, w);
    send(64'hC3C3_0000_0000_0003, 3, w);
    check("b2b_accept_wait", 128'(w), 128'(1));
    drain();

    // Backpressure pattern on a count-3 instruction.
    send(64'hD3D3_0000_0000_0003, 3, w);
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    idle(6);
    #3;
    check("bp_all_taken", 128'(exp_q.size()), 128'(0));
    drain();

    // Boundary counts: 0 -> 1, 8 -> 8, 9 and 15 -> 8.
    send(64'h0000_0000_0000_0000, 0, w);
    drain();
    send(64'h8888_8888_8888_8888, 8, w);
    drain();
    send(64'h9999_9999_9999_9999, 9, w);
    drain();
    send(64'hFFFF_0000_FFFF_000F, 15, w);
    drain();

    // Reset after idx 2 of a count-5 instruction fires.
    send(64'hE5E5_0000_0000_0005, 5, w);
    idle(3);
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_mid_state", 128'({out_valid, in_ready}), 128'({1'b0, 1'b1}));
    check("rst_mid_remaining", 128'(exp_q.size()), 128'(2));
    exp_q.delete();
    idle(4);

    // Random valid/ready stress with random counts.
    rand_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send({$urandom, $urandom}, $urandom_range(0, 10), w);
    end
    drain();
    rand_ready = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
